// File: rtl/apb_to_axi_lite.sv
// apb_to_axi_lite: APB4 completer to AXI4-Lite manager bridge, one transfer in flight.
// Define APB_TO_AXI_LITE_PSTRB_EN to forward pstrb onto w.strb; otherwise writes use all-ones strobes.
package apb_to_axi_lite_pkg;
    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  pprot;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb_req_t;
    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb_resp_t;
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_chan_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_chan_t;
    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_lite_req_t;
    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } axi_lite_resp_t;
endpackage

module apb_to_axi_lite #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter type apb_req_t = apb_to_axi_lite_pkg::apb_req_t,
    parameter type apb_resp_t = apb_to_axi_lite_pkg::apb_resp_t,
    parameter type axi_lite_req_t = apb_to_axi_lite_pkg::axi_lite_req_t,
    parameter type axi_lite_resp_t = apb_to_axi_lite_pkg::axi_lite_resp_t
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  apb_req_t       apb_req_i,
    output apb_resp_t      apb_resp_o,
    output axi_lite_req_t  axi_lite_req_o,
    input  axi_lite_resp_t axi_lite_resp_i
);
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_e;
    state_e                 state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [2:0]             prot_q;
    logic [DataWidth-1:0]   wdata_q, prdata_q;
    logic [DataWidth/8-1:0] strb_q;
    logic aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q, pready_q, pslverr_q;
    logic aw_fin, w_fin;
    // A write channel is finished once its valid has dropped or it handshakes this cycle.
    assign aw_fin = !aw_valid_q || axi_lite_resp_i.aw_ready;
    assign w_fin  = !w_valid_q || axi_lite_resp_i.w_ready;
    // Transfer sequencer: capture at APB setup, drive AXI, register the response for one pready cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            prot_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            pready_q   <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (apb_req_i.psel && !apb_req_i.penable) begin
                    addr_q     <= apb_req_i.paddr;
                    prot_q     <= apb_req_i.pprot;
                    wdata_q    <= apb_req_i.pwdata;
                    strb_q     <= apb_req_i.pstrb;
                    aw_valid_q <= apb_req_i.pwrite;
                    w_valid_q  <= apb_req_i.pwrite;
                    ar_valid_q <= !apb_req_i.pwrite;
                    state_q    <= apb_req_i.pwrite ? WRITE : READ;
                end
                WRITE: begin
                    if (axi_lite_resp_i.aw_ready) aw_valid_q <= 1'b0;
                    if (axi_lite_resp_i.w_ready) w_valid_q <= 1'b0;
                    if (aw_fin && w_fin) begin
                        b_ready_q <= 1'b1;
                        state_q   <= WAIT_B;
                    end
                end
                WAIT_B: if (axi_lite_resp_i.b_valid) begin
                    b_ready_q <= 1'b0;
                    pslverr_q <= axi_lite_resp_i.b.resp[1];
                    prdata_q  <= '0;
                    pready_q  <= 1'b1;
                    state_q   <= RESP;
                end
                READ: if (axi_lite_resp_i.ar_ready) begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b1;
                    state_q    <= WAIT_R;
                end
                WAIT_R: if (axi_lite_resp_i.r_valid) begin
                    r_ready_q <= 1'b0;
                    prdata_q  <= axi_lite_resp_i.r.data;
                    pslverr_q <= axi_lite_resp_i.r.resp[1];
                    pready_q  <= 1'b1;
                    state_q   <= RESP;
                end
                RESP: begin
                    pready_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Output mapping; pready is suppressed when the initiator has already dropped psel.
    always_comb begin
        apb_resp_o              = '0;
        apb_resp_o.pready       = pready_q && apb_req_i.psel;
        apb_resp_o.prdata       = prdata_q;
        apb_resp_o.pslverr      = pslverr_q;
        axi_lite_req_o          = '0;
        axi_lite_req_o.aw.addr  = addr_q;
        axi_lite_req_o.aw.prot  = prot_q;
        axi_lite_req_o.aw_valid = aw_valid_q;
        axi_lite_req_o.w.data   = wdata_q;
`ifdef APB_TO_AXI_LITE_PSTRB_EN
        axi_lite_req_o.w.strb   = strb_q;
`else
        axi_lite_req_o.w.strb   = '1;
`endif
        axi_lite_req_o.w_valid  = w_valid_q;
        axi_lite_req_o.b_ready  = b_ready_q;
        axi_lite_req_o.ar.addr  = addr_q;
        axi_lite_req_o.ar.prot  = prot_q;
        axi_lite_req_o.ar_valid = ar_valid_q;
        axi_lite_req_o.r_ready  = r_ready_q;
    end
    logic unused_bits;
`ifdef APB_TO_AXI_LITE_PSTRB_EN
    assign unused_bits = ^{axi_lite_resp_i.b.resp[0], axi_lite_resp_i.r.resp[0]};
`else
    assign unused_bits = ^{axi_lite_resp_i.b.resp[0], axi_lite_resp_i.r.resp[0], strb_q};
`endif
endmodule

// File: tb/tb_apb_to_axi_lite.sv
// tb_apb_to_axi_lite: table-driven, directed and randomized checks of the APB-to-AXI-Lite bridge.
module tb_apb_to_axi_lite;
    import apb_to_axi_lite_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    apb_req_t       apb_req;
    apb_resp_t      apb_resp;
    axi_lite_req_t  axi_req;
    axi_lite_resp_t axi_resp;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Subordinate configuration: fixed delays, or per-cycle random readiness when rnd is set.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    bit rnd = 1'b0;
    logic [1:0]  b_rsp = 2'b00, r_rsp = 2'b00;
    logic [31:0] r_dat = '0;

    // Handshakes observed on the AXI side, with the cycle they happened in.
    ax_chan_t aw_q[$], ar_q[$];
    w_chan_t  w_q[$];
    int       aw_t[$], ar_t[$];

    always #5 clk = ~clk;

    apb_to_axi_lite dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .apb_req_i      (apb_req),
        .apb_resp_o     (apb_resp),
        .axi_lite_req_o (axi_req),
        .axi_lite_resp_i(axi_resp)
    );

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bit go(input int cnt, input int dly);
        return rnd ? ($urandom_range(0, 3) != 0) : (cnt >= dly);
    endfunction

    // AXI-Lite subordinate and protocol monitor, acting on the falling edge.
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c, n_aw, n_w, n_ar, n_b, n_r;
        logic aw_hs, w_hs, ar_hs, b_hs, r_hs, pr_q;
        axi_lite_req_t prev;
        axi_resp = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                axi_resp = '0;
                prev = '0;
                {aw_c, w_c, ar_c, b_c, r_c, n_aw, n_w, n_ar, n_b, n_r} = '0;
                {aw_hs, w_hs, ar_hs, b_hs, r_hs, pr_q} = '0;
                continue;
            end
            if (prev.aw_valid && !aw_hs) chk("aw_stable", {axi_req.aw_valid, axi_req.aw}, {1'b1, prev.aw});
            if (prev.w_valid && !w_hs) chk("w_stable", {axi_req.w_valid, axi_req.w}, {1'b1, prev.w});
            if (prev.ar_valid && !ar_hs) chk("ar_stable", {axi_req.ar_valid, axi_req.ar}, {1'b1, prev.ar});
            if (apb_resp.pready) begin
                chk("pready_single_cycle", pr_q, 0);
                chk("pready_in_access", {apb_req.psel, apb_req.penable}, 2'b11);
            end
            pr_q = apb_resp.pready;
            if (b_hs) axi_resp.b_valid = 1'b0;
            if (r_hs) axi_resp.r_valid = 1'b0;
            if (!axi_resp.b_valid && n_aw > n_b && n_w > n_b) begin
                if (go(b_c, b_dly)) begin
                    axi_resp.b_valid = 1'b1;
                    axi_resp.b.resp = b_rsp;
                    b_c = 0;
                end else b_c++;
            end
            b_hs = axi_resp.b_valid && axi_req.b_ready;
            if (b_hs) n_b++;
            if (!axi_resp.r_valid && n_ar > n_r) begin
                if (go(r_c, r_dly)) begin
                    axi_resp.r_valid = 1'b1;
                    axi_resp.r.data = r_dat;
                    axi_resp.r.resp = r_rsp;
                    r_c = 0;
                end else r_c++;
            end
            r_hs = axi_resp.r_valid && axi_req.r_ready;
            if (r_hs) n_r++;
            axi_resp.aw_ready = axi_req.aw_valid && go(aw_c, aw_dly);
            aw_hs = axi_req.aw_valid && axi_resp.aw_ready;
            aw_c = (axi_req.aw_valid && !aw_hs) ? aw_c + 1 : 0;
            if (aw_hs) begin aw_q.push_back(axi_req.aw); aw_t.push_back(cyc); n_aw++; end
            axi_resp.w_ready = axi_req.w_valid && go(w_c, w_dly);
            w_hs = axi_req.w_valid && axi_resp.w_ready;
            w_c = (axi_req.w_valid && !w_hs) ? w_c + 1 : 0;
            if (w_hs) begin w_q.push_back(axi_req.w); n_w++; end
            axi_resp.ar_ready = axi_req.ar_valid && go(ar_c, ar_dly);
            ar_hs = axi_req.ar_valid && axi_resp.ar_ready;
            ar_c = (axi_req.ar_valid && !ar_hs) ? ar_c + 1 : 0;
            if (ar_hs) begin ar_q.push_back(axi_req.ar); ar_t.push_back(cyc); n_ar++; end
            prev = axi_req;
        end
    end

    // One APB transfer starting at a falling edge; returns one edge after the pready cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot,
                        output logic [31:0] rdata, output logic err, output int lat);
        apb_req.psel = 1'b1;
        apb_req.penable = 1'b0;
        apb_req.pwrite = wr;
        apb_req.paddr = addr;
        apb_req.pwdata = wdata;
        apb_req.pstrb = strb;
        apb_req.pprot = prot;
        @(negedge clk);
        apb_req.penable = 1'b1;
        lat = 1;
        while (!apb_resp.pready && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!apb_resp.pready) chk("pready_timeout", 0, 1);
        rdata = apb_resp.prdata;
        err = apb_resp.pslverr;
        @(negedge clk);
    endtask

    task automatic idle();
        apb_req.psel = 1'b0;
        apb_req.penable = 1'b0;
        @(negedge clk);
    endtask

    // Reference: each APB transfer yields exactly one AW+W (write) or one AR (read) carrying the captured fields.
    task automatic check_axi(input string nm, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        logic [3:0] es;
`ifdef APB_TO_AXI_LITE_PSTRB_EN
        es = strb;
`else
        es = 4'hF;
`endif
        chk({nm, "_axi_count"}, {8'(aw_q.size()), 8'(w_q.size()), 8'(ar_q.size())}, wr ? 24'h010100 : 24'h000001);
        if (wr && aw_q.size() > 0) chk({nm, "_aw"}, aw_q[0], {addr, prot});
        if (wr && w_q.size() > 0) chk({nm, "_w"}, w_q[0], {wdata, es});
        if (!wr && ar_q.size() > 0) chk({nm, "_ar"}, ar_q[0], {addr, prot});
        aw_q.delete(); w_q.delete(); ar_q.delete(); aw_t.delete(); ar_t.delete();
    endtask

    typedef struct {
        logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
        int aw_d; int w_d; int b_d; int ar_d; int r_d;
        logic [1:0] b_r; logic [1:0] r_r; logic [31:0] r_dt;
        logic [31:0] e_rdata; logic e_err; int e_lat;
    } vec_t;

    initial begin
        vec_t v[6];
        logic [31:0] rd;
        logic er;
        int lat, t_ar;
        v[0] = '{1'b1, 32'h1000, 32'hDEADBEEF, 4'b0101, 3'b000, 3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 6};
        v[1] = '{1'b0, 32'h2004, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b10, 32'h12345678, 32'h12345678, 1'b1, 3};
        v[2] = '{1'b1, 32'h3008, 32'hCAFEF00D, 4'b1100, 3'b001, 2, 0, 0, 0, 0, 2'b11, 2'b00, 32'h0, 32'h0, 1'b1, 5};
        v[3] = '{1'b0, 32'h0040, 32'h0, 4'h0, 3'b111, 0, 0, 0, 1, 2, 2'b00, 2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 6};
        v[4] = '{1'b1, 32'h5003, 32'h01020304, 4'b0001, 3'b100, 0, 4, 1, 0, 0, 2'b01, 2'b00, 32'h0, 32'h0, 1'b0, 8};
        v[5] = '{1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 2'b11, 32'h0BADF00D, 32'h0BADF00D, 1'b1, 3};
        apb_req = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid,
                              axi_req.r_ready, apb_resp.pready, apb_resp.pslverr, apb_resp.prdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            {aw_dly, w_dly, b_dly, ar_dly, r_dly} = {v[i].aw_d, v[i].w_d, v[i].b_d, v[i].ar_d, v[i].r_d};
            {b_rsp, r_rsp, r_dat} = {v[i].b_r, v[i].r_r, v[i].r_dt};
            xfer(v[i].wr, v[i].addr, v[i].wdata, v[i].strb, v[i].prot, rd, er, lat);
            chk($sformatf("vec%0d_prdata", i), rd, v[i].e_rdata);
            chk($sformatf("vec%0d_pslverr", i), er, v[i].e_err);
            chk($sformatf("vec%0d_latency", i), lat, v[i].e_lat);
            check_axi($sformatf("vec%0d", i), v[i].wr, v[i].addr, v[i].wdata, v[i].strb, v[i].prot);
            idle();
        end
        // Back-to-back read then write with no idle cycle between them.
        {aw_dly, w_dly, b_dly, ar_dly, r_dly} = '0;
        {b_rsp, r_rsp, r_dat} = {2'b00, 2'b00, 32'h11112222};
        xfer(1'b0, 32'h6000, 32'h0, 4'h0, 3'b010, rd, er, lat);
        chk("b2b_read_data", {er, rd}, {1'b0, 32'h11112222});
        chk("b2b_read_latency", lat, 3);
        t_ar = ar_t.size() > 0 ? ar_t[0] : 1 << 30;
        check_axi("b2b_read", 1'b0, 32'h6000, 32'h0, 4'h0, 3'b010);
        xfer(1'b1, 32'h7000, 32'h55AA55AA, 4'b0011, 3'b010, rd, er, lat);
        chk("b2b_write_latency", lat, 3);
        chk("b2b_order", aw_t.size() > 0 && aw_t[0] > t_ar, 1);
        chk("b2b_write_resp", {er, rd}, 0);
        check_axi("b2b_write", 1'b1, 32'h7000, 32'h55AA55AA, 4'b0011, 3'b010);
        idle();
        // Asynchronous reset while waiting for R, then a clean read.
        r_dly = 20;
        apb_req.psel = 1'b1; apb_req.penable = 1'b0; apb_req.pwrite = 1'b0; apb_req.paddr = 32'h8000;
        @(negedge clk);
        apb_req.penable = 1'b1;
        repeat (2) @(negedge clk);
        chk("wait_r_reached", {axi_req.r_ready, axi_req.ar_valid}, 2'b10);
        #1 rst = 1'b1;
        #1 chk("reset_async", {axi_req.aw_valid, axi_req.w_valid, axi_req.b_ready, axi_req.ar_valid,
                               axi_req.r_ready, apb_resp.pready}, 0);
        apb_req = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        aw_q.delete(); w_q.delete(); ar_q.delete(); aw_t.delete(); ar_t.delete();
        r_dly = 0;
        {r_rsp, r_dat} = {2'b00, 32'h0F0F0F0F};
        xfer(1'b0, 32'h9000, 32'h0, 4'h0, 3'b001, rd, er, lat);
        chk("post_reset_read", {er, rd}, {1'b0, 32'h0F0F0F0F});
        chk("post_reset_latency", lat, 3);
        check_axi("post_reset", 1'b0, 32'h9000, 32'h0, 4'h0, 3'b001);
        idle();
        // Random traffic against a random-ready subordinate.
        rnd = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic wr;
            logic [31:0] a, d;
            logic [3:0] s;
            logic [2:0] p;
            wr = 1'($urandom_range(0, 1));
            a = $urandom; d = $urandom; s = 4'($urandom); p = 3'($urandom);
            b_rsp = 2'($urandom); r_rsp = 2'($urandom); r_dat = $urandom;
            xfer(wr, a, d, s, p, rd, er, lat);
            chk("rand_pslverr", er, wr ? b_rsp[1] : r_rsp[1]);
            chk("rand_prdata", rd, wr ? 32'h0 : r_dat);
            check_axi("rand", wr, a, d, s, p);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
